// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: instruction fetch with a DEPTH-entry prefetch queue, in-order tag FIFO and branch redirect.
// Define IF_BYPASS_EN to forward a response straight into IF/ID when the queue is empty.
module if_prefetch_stage #(
    parameter int RW = 24,
    parameter int IW = 32,
    parameter int DEPTH = 4,
    parameter int PC_STEP = 4,
    parameter logic [RW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             branchFlag,
    input  logic [RW-1:0]    branchAddr,
    output logic             imem_req,
    output logic [RW-1:0]    imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [IW-1:0]    imem_rdata,
    output logic [IW+RW-1:0] bufferOut,
    output logic             valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 8;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    logic [IW+RW-1:0] r_q [DEPTH];
    logic [RW-1:0]    r_tag [DEPTH];
    logic [PW-1:0]    r_head, r_tail, r_thead, r_ttail;
    logic [CW-1:0]    r_count, r_out;
    logic [DW-1:0]    r_discard;
    logic [RW-1:0]    r_fpc;

    logic             w_fire, w_live, w_byp, w_push, w_pop;
    logic [IW+RW-1:0] w_resp;

    // Credit covers both queued and in-flight current-path fetches, so the queue cannot overflow.
    assign imem_req  = !rst && !branchFlag && ({1'b0, r_out} + {1'b0, r_count} < DEPTH_C);
    assign imem_addr = r_fpc;
    assign w_fire    = imem_req && imem_gnt;
    assign w_live    = imem_rvalid && r_discard == '0;
    assign w_resp    = {imem_rdata, r_tag[r_thead]};
`ifdef IF_BYPASS_EN
    assign w_byp     = en && !branchFlag && r_count == '0 && w_live;
`else
    assign w_byp     = 1'b0;
`endif
    assign w_push    = w_live && !branchFlag && !w_byp;
    assign w_pop     = en && !branchFlag && r_count != '0;

    always_ff @(posedge clk) begin
        if (w_push) r_q[r_tail] <= w_resp;
        if (w_fire) r_tag[r_ttail] <= r_fpc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc     <= RESET_PC;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_thead   <= '0;
            r_ttail   <= '0;
            r_out     <= '0;
            r_discard <= '0;
            bufferOut <= '0;
            valid     <= 1'b0;
        end else if (branchFlag) begin
            r_fpc     <= branchAddr;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_thead   <= '0;
            r_ttail   <= '0;
            r_out     <= '0;
            // Everything still in flight, old-path or not, now belongs to the wrong path.
            r_discard <= r_discard + DW'(r_out) - DW'(imem_rvalid);
            bufferOut <= '0;
            valid     <= 1'b0;
        end else begin
            if (w_fire) begin
                r_fpc  <= r_fpc + RW'(PC_STEP);
                r_ttail <= r_ttail + 1'b1;
            end
            if (w_live) r_thead <= r_thead + 1'b1;
            if (imem_rvalid && r_discard != '0) r_discard <= r_discard - 1'b1;
            r_out <= r_out + CW'(w_fire) - CW'(w_live);
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop) r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (en) begin
                bufferOut <= w_pop ? r_q[r_head] : w_byp ? w_resp : '0;
                valid     <= w_pop || w_byp;
            end
        end
    end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage: table, directed and random checks of if_prefetch_stage against a queue-based model.
module tb_if_prefetch_stage;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, en, branchFlag, imem_gnt, imem_rvalid;
    logic [23:0] branchAddr;
    logic        imem_req;
    logic [23:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [55:0] bufferOut;
    logic        valid;

    if_prefetch_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .branchFlag(branchFlag), .branchAddr(branchAddr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .bufferOut(bufferOut), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] addr; logic live; } inf_t;
    typedef struct { logic [23:0] addr; int due; } pend_t;
    typedef struct { logic en; logic gnt; logic exp_req; logic [23:0] exp_addr; logic exp_valid; logic [23:0] exp_pc; } vec_t;

    inf_t        inflight[$];
    pend_t       pend[$];
    logic [55:0] fifo[$];
    logic [23:0] m_fpc;
    logic [55:0] m_buf;
    logic        m_valid;
    int          cyc, lat, vectors, miscompares;
    logic        rnd_rv, s_req;
    logic [23:0] s_addr;
    vec_t        tbl[8];

    function automatic logic [31:0] inst_of(logic [23:0] a);
        return {8'hC3, a ^ 24'h5A5A5A};
    endfunction

    function automatic int live_count();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].live) n++;
        return n;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic        fire, m_req, live, byp;
        logic [55:0] ent;
        inf_t        r, n;
        pend_t       p;
        imem_rvalid = !rst && pend.size() > 0 && pend[0].due <= cyc && (!rnd_rv || $urandom_range(3) != 0);
        imem_rdata  = imem_rvalid ? inst_of(pend[0].addr) : $urandom;
        #1;
        m_req = !rst && !branchFlag && (live_count() + fifo.size()) < DEPTH;
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_fpc);
        s_req  = imem_req;
        s_addr = imem_addr;
        fire   = imem_req && imem_gnt;
        @(posedge clk);
        if (rst) pend.delete();
        else begin
            if (imem_rvalid) void'(pend.pop_front());
            if (fire) begin p.addr = s_addr; p.due = cyc + lat; pend.push_back(p); end
        end
        if (rst) begin
            m_fpc = 24'h0; inflight.delete(); fifo.delete(); m_buf = '0; m_valid = 1'b0;
        end else begin
            live = 1'b0;
            ent  = {imem_rdata, 24'h0};
            if (imem_rvalid && inflight.size() > 0) begin
                r = inflight.pop_front();
                live = r.live;
                ent = {imem_rdata, r.addr};
            end
            if (branchFlag) begin
                fifo.delete();
                foreach (inflight[i]) inflight[i].live = 1'b0;
                m_buf = '0; m_valid = 1'b0; m_fpc = branchAddr;
            end else begin
                byp = 1'b0;
`ifdef IF_BYPASS_EN
                byp = en && fifo.size() == 0 && live;
`endif
                if (en) begin
                    if (fifo.size() > 0) begin m_buf = fifo.pop_front(); m_valid = 1'b1; end
                    else begin m_buf = byp ? ent : '0; m_valid = byp; end
                end
                if (live && !byp) fifo.push_back(ent);
                if (m_req && imem_gnt) begin n.addr = m_fpc; n.live = 1'b1; inflight.push_back(n); m_fpc += 24'd4; end
            end
        end
        cyc++;
        #1;
        chk("bufferOut", bufferOut, m_buf);
        chk("valid", valid, m_valid);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_first_pc(string name, logic [23:0] pc);
        logic found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin step(); found = valid; end
        chk({name, "_found"}, found, 1'b1);
        if (found) chk({name, "_pc"}, bufferOut[23:0], pc);
    endtask

    initial begin
        int dly;
`ifdef IF_BYPASS_EN
        dly = 1;
`else
        dly = 2;
`endif
        for (int i = 0; i < 8; i++) begin
            tbl[i].en = 1'b1; tbl[i].gnt = 1'b1; tbl[i].exp_req = 1'b1;
            tbl[i].exp_addr = 24'(4 * i);
            tbl[i].exp_valid = i >= dly;
            tbl[i].exp_pc = i >= dly ? 24'(4 * (i - dly)) : 24'h0;
        end
        vectors = 0; miscompares = 0; cyc = 0; lat = 1; rnd_rv = 1'b0;
        rst = 1'b1; en = 1'b0; branchFlag = 1'b0; branchAddr = '0; imem_gnt = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0;
        m_fpc = '0; m_buf = '0; m_valid = 1'b0;
        @(posedge clk); #1;
        run(2);
        chk("reset_req", s_req, 1'b0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_buf", bufferOut, 56'h0);
        rst = 1'b0;
        foreach (tbl[i]) begin
            en = tbl[i].en; imem_gnt = tbl[i].gnt;
            step();
            chk("tbl_req", s_req, tbl[i].exp_req);
            chk("tbl_addr", s_addr, tbl[i].exp_addr);
            chk("tbl_valid", valid, tbl[i].exp_valid);
            chk("tbl_buf", bufferOut, tbl[i].exp_valid ? {inst_of(tbl[i].exp_pc), tbl[i].exp_pc} : 56'h0);
        end
        en = 1'b0; run(6);
        chk("stall_req", s_req, 1'b0);
        en = 1'b1; run(12);
        lat = 3; run(8);
        branchFlag = 1'b1; branchAddr = 24'h000100; step();
        branchFlag = 1'b0;
        chk("redir_valid", valid, 1'b0);
        wait_first_pc("redir", 24'h000100);
        run(6);
        lat = 1; en = 1'b0; branchFlag = 1'b1; branchAddr = 24'h000200; step();
        branchFlag = 1'b0;
        chk("redir_stall_valid", valid, 1'b0);
        chk("redir_stall_buf", bufferOut, 56'h0);
        en = 1'b1;
        wait_first_pc("redir_stall", 24'h000200);
        run(6);
        imem_gnt = 1'b0; run(5);
        chk("gnt_hold_valid", valid, 1'b0);
        imem_gnt = 1'b1; run(8);
        en = 1'b0; run(2);
        rst = 1'b1; step();
        chk("rst_mid_valid", valid, 1'b0);
        chk("rst_mid_buf", bufferOut, 56'h0);
        rst = 1'b0; en = 1'b1; step();
        chk("rst_mid_addr", s_addr, 24'h0);
        run(6);
        rnd_rv = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst        = $urandom_range(199) == 0;
            en         = $urandom_range(3) != 0;
            branchFlag = $urandom_range(29) == 0;
            branchAddr = 24'($urandom) & 24'hFFFFFC;
            imem_gnt   = $urandom_range(3) != 0;
            lat        = $urandom_range(4, 1);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
